// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared 7-segment definitions: active-low hex glyph table,
//             blank pattern, nibble type and capture FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] nibble_t;

    // Active-low glyphs, bit0 = a ... bit6 = g. Entry i is the glyph for hex i.
    localparam logic [15:0][6:0] SEG7_CODE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Capture FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational reverse decoder: active-low 7-segment pattern to
//             hex nibble, with a flag when the pattern is a legal glyph.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output nibble_t    o_nib,
    output logic       o_valid
);

    logic    w_hit;
    nibble_t w_nib;

    // Table match against every glyph; entries are unique so at most one hits
    always_comb begin
        w_hit = 1'b0;
        w_nib = '0;
        for (int i = 0; i < 16; i++) begin
            if (i_pat == SEG7_CODE[i]) begin
                w_hit = 1'b1;
                w_nib = nibble_t'(i);
            end
        end
    end

    assign o_nib   = w_nib;
    // A dark digit is never a legal value, whatever the table holds
    assign o_valid = w_hit && (i_pat != SEG7_BLANK);

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture
//  Purpose  : Receive side of a multiplexed 7-segment bus. Synchronizes the
//             segment/strobe lines, waits for a stable sample, decodes each
//             digit and publishes complete frames atomically on oDIG.
//  Options  : define SEG7_CAPTURE_DP_EN to add decimal-point capture
//             (ports iDP / oDP).
//  Revision : 1.0  initial release
// ============================================================================
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [6:0]             iSEG,
    input  logic [NUM_DIG-1:0]     iSEL,
    input  logic                   iCLR,
`ifdef SEG7_CAPTURE_DP_EN
    input  logic                   iDP,
`endif
    output logic [4*NUM_DIG-1:0]   oDIG,
    output logic [NUM_DIG-1:0]     oDIG_VALID,
    output logic                   oFRAME,
    output logic                   oERR
`ifdef SEG7_CAPTURE_DP_EN
    ,
    output logic [NUM_DIG-1:0]     oDP
`endif
);

    localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
`ifdef SEG7_CAPTURE_DP_EN
    localparam int SW = NUM_DIG + 8;
`else
    localparam int SW = NUM_DIG + 7;
`endif

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [6:0]         r_seg_s1, r_seg_s2;
    logic [NUM_DIG-1:0] r_sel_s1, r_sel_s2;
    logic [SW-1:0]      w_samp;

`ifdef SEG7_CAPTURE_DP_EN
    logic               r_dp_s1, r_dp_s2;

    // Two-flop synchronizer for the decimal point line
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_dp_s1 <= 1'b0;
            r_dp_s2 <= 1'b0;
        end else begin
            r_dp_s1 <= iDP;
            r_dp_s2 <= r_dp_s1;
        end
    end

    assign w_samp = {r_dp_s2, r_sel_s2, r_seg_s2};
`else
    assign w_samp = {r_sel_s2, r_seg_s2};
`endif

    // Two-flop synchronizers for segment and strobe lines
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
        end else begin
            r_seg_s1 <= iSEG;
            r_seg_s2 <= r_seg_s1;
            r_sel_s1 <= iSEL;
            r_sel_s2 <= r_sel_s1;
        end
    end

    // ------------------------------------------------------------------
    // Stability counter. w_run is the number of extra identical samples
    // seen including the current one, so a capture can fire in the very
    // cycle the STABLE_CYC-th identical sample is present.
    // ------------------------------------------------------------------
    logic [SW-1:0]    r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_run;
    logic             w_match;

    assign w_match = (w_samp == r_prev);
    assign w_run   = !w_match           ? '0 :
                     (r_cnt == CNT_MAX) ? CNT_MAX :
                                          r_cnt + CNT_W'(1);

    // Track the previous sample and its run length
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_samp;
            r_cnt  <= w_run;
        end
    end

    // ------------------------------------------------------------------
    // Strobe analysis and decode
    // ------------------------------------------------------------------
    logic             w_sel_nz;
    logic             w_multi;
    logic [IDX_W-1:0] w_idx;
    nibble_t          w_dec_nib;
    logic             w_dec_valid;

    assign w_sel_nz = |r_sel_s2;
    // Clearing the lowest set bit leaves something only if two or more are set
    assign w_multi  = |(r_sel_s2 & (r_sel_s2 - NUM_DIG'(1)));

    // Index of the active strobe bit (meaningful only when one-hot)
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (r_sel_s2[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    seg7_decode u_decode (
        .i_pat   (r_seg_s2),
        .o_nib   (w_dec_nib),
        .o_valid (w_dec_valid)
    );

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state, w_state_next;
    logic       w_cap;

    assign w_cap = (r_state == ST_SETTLE) && w_sel_nz && (w_run == CNT_MAX);

    // Next-state: one capture per stable period, re-armed by any change
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_nz) w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!w_sel_nz)
                    w_state_next = ST_IDLE;
                else if (w_run == CNT_MAX)
                    w_state_next = ST_HELD;
            end
            ST_HELD: begin
                if (!w_match) w_state_next = w_sel_nz ? ST_SETTLE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    logic [NUM_DIG-1:0][3:0] r_shadow;
    logic [NUM_DIG-1:0]      r_mask, w_mask_next;
    logic [4*NUM_DIG-1:0]    r_dig;
    logic                    r_frame, r_err;
    logic                    w_full, w_wr, w_bad;

    assign w_full = &r_mask;
    assign w_bad  = w_cap && (w_multi || !w_dec_valid);
    // iCLR drops a coincident capture entirely
    assign w_wr   = w_cap && !w_multi && w_dec_valid && !iCLR;

    // Mask: frame completion clears first, then a same-cycle capture lands
    always_comb begin
        w_mask_next = w_full ? '0 : r_mask;
        if (w_wr) w_mask_next[w_idx] = 1'b1;
        if (iCLR) w_mask_next = '0;
    end

    // Shadow nibble write on a good capture
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_shadow <= '0;
        else if (w_wr) r_shadow[w_idx] <= w_dec_nib;
    end

    // Mask, frame publication and status pulses
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_mask  <= '0;
            r_dig   <= '0;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_mask  <= w_mask_next;
            r_frame <= w_full;
            r_err   <= w_bad;
            if (w_full) r_dig <= r_shadow;
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic [NUM_DIG-1:0] r_dp_shadow, r_dp;

    // Decimal points: stored active-high, published with the frame
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_dp_shadow <= '0;
            r_dp        <= '0;
        end else begin
            if (w_wr)   r_dp_shadow[w_idx] <= ~r_dp_s2;
            if (w_full) r_dp <= r_dp_shadow;
        end
    end

    assign oDP = r_dp;
`endif

    assign oDIG       = r_dig;
    assign oDIG_VALID = r_mask;
    assign oFRAME     = r_frame;
    assign oERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture
//  Purpose  : Self-checking bench for seg7_capture. A sample-level model
//             (delay line, run length of identical samples, frame mask)
//             predicts every output each cycle; directed checks pin it.
//  Options  : honours SEG7_CAPTURE_DP_EN like the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_capture;

    localparam int ND = 8;
    localparam int SC = 4;

    logic          clk;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] sel;
    logic          clr;
    logic          dp_in;
    logic [31:0]   dig;
    logic [ND-1:0] valid;
    logic          frame;
    logic          err;
`ifdef SEG7_CAPTURE_DP_EN
    logic [ND-1:0] dpo;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_frames = 0;
    int n_errs  = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_capture #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSEG       (seg),
        .iSEL       (sel),
        .iCLR       (clr),
`ifdef SEG7_CAPTURE_DP_EN
        .iDP        (dp_in),
`endif
        .oDIG       (dig),
        .oDIG_VALID (valid),
        .oFRAME     (frame),
        .oERR       (err)
`ifdef SEG7_CAPTURE_DP_EN
        ,
        .oDP        (dpo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          dp;
        logic [ND-1:0] sel;
        logic [6:0]    seg;
    } samp_t;

    samp_t         m_d1, m_d2, m_last;
    int            m_run;
    bit            m_done;
    logic [ND-1:0] m_mask;
    logic [3:0]    m_sh [ND];
    logic [31:0]   m_dig;
    logic          m_frame, m_err;
    logic [ND-1:0] m_dpsh, m_dp;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : p_model
        samp_t         s;
        int            run_n;
        bit            done_n;
        bit            cap;
        bit            full;
        int            nib;
        int            k;
        logic [ND-1:0] mask_n;
        if (rst) begin
            m_d1    <= '0;
            m_d2    <= '0;
            m_last  <= '0;
            m_run   <= 0;
            m_done  <= 1'b1;
            m_mask  <= '0;
            m_dig   <= '0;
            m_frame <= 1'b0;
            m_err   <= 1'b0;
            m_dpsh  <= '0;
            m_dp    <= '0;
            for (int i = 0; i < ND; i++) m_sh[i] <= 4'h0;
        end else begin
            // The sample the design acts on is the input from two edges ago
            s = m_d2;
            m_d2 <= m_d1;
            m_d1 <= {dp_in, sel, seg};
            if (s == m_last) begin
                run_n  = (m_run < 1000) ? m_run + 1 : m_run;
                done_n = m_done;
            end else begin
                run_n  = 1;
                done_n = 1'b0;
            end
            cap = (run_n >= SC) && !done_n && (s.sel != '0);
            if (cap) done_n = 1'b1;
            m_last <= s;
            m_run  <= run_n;
            m_done <= done_n;

            full = (m_mask == '1);
            m_frame <= full;
            mask_n = full ? '0 : m_mask;
            if (full) begin
                for (int i = 0; i < ND; i++) m_dig[4*i +: 4] <= m_sh[i];
                m_dp <= m_dpsh;
            end
            m_err <= 1'b0;
            if (cap) begin
                nib = lookup(s.seg);
                if ($countones(s.sel) != 1 || nib < 0) begin
                    m_err <= 1'b1;
                end else if (!clr) begin
                    k = 0;
                    for (int i = 0; i < ND; i++) if (s.sel[i]) k = i;
                    m_sh[k]   <= nib[3:0];
                    m_dpsh[k] <= ~s.dp;
                    mask_n[k] = 1'b1;
                end
            end
            if (clr) mask_n = '0;
            m_mask <= mask_n;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        n_tests++;
        if (dig !== m_dig || valid !== m_mask || frame !== m_frame || err !== m_err
`ifdef SEG7_CAPTURE_DP_EN
            || dpo !== m_dp
`endif
           ) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t dig=%h want %h valid=%h want %h frame=%b want %b err=%b want %b",
                     $time, dig, m_dig, valid, m_mask, frame, m_frame, err, m_err);
        end
        if (frame === 1'b1) n_frames++;
        if (err === 1'b1)   n_errs++;
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [ND-1:0] s, input logic [6:0] code, input int n, input logic d);
        sel   = s;
        seg   = code;
        dp_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int k, input logic [6:0] code, input int n, input logic d);
        logic [ND-1:0] s;
        s = '0;
        s[k] = 1'b1;
        drive(s, code, n, d);
    endtask

    task automatic blank(input int n);
        drive('0, 7'h7F, n, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : p_stim
        int e0;
        rst   = 1'b0;
        clr   = 1'b0;
        sel   = '0;
        seg   = 7'h7F;
        dp_in = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dig",   dig,   32'h0);
        check("reset_valid", valid, 8'h00);
        check("reset_frame", frame, 1'b0);
        check("reset_err",   err,   1'b0);
        rst = 1'b0;
        blank(4);

        // Full frame: digit k shows 8-k
        for (int k = 0; k < ND; k++) begin
            show(k, codes[8-k], 10, 1'b1);
            blank(2);
        end
        blank(8);
        check("frame_dig",    dig,      32'h12345678);
        check("frame_pulses", n_frames, 1);
        check("frame_no_err", n_errs,   0);
        check("frame_mask",   valid,    8'h00);

        // Glitch filter: 3 identical samples are not enough, 4 are
        drive(8'h01, 7'h79, 3, 1'b1);
        blank(6);
        check("glitch_3", valid, 8'h00);
        drive(8'h01, 7'h79, 4, 1'b1);
        blank(6);
        check("glitch_4", valid, 8'h01);

        // Overwrite digit 0 (5 then A), complete the frame
        show(0, codes[5], 10, 1'b1);
        blank(2);
        show(0, codes[10], 10, 1'b1);
        blank(4);
        check("overwrite_mask", valid, 8'h01);
        for (int k = 1; k < ND; k++) begin
            show(k, codes[k], 10, 1'b1);
            blank(2);
        end
        blank(6);
        check("overwrite_dig", dig,      32'h7654321A);
        check("overwrite_fr",  n_frames, 2);

        // iCLR drops the partial frame, keeps oDIG
        show(3, codes[9], 10, 1'b1);
        blank(4);
        check("clr_before", valid, 8'h08);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_mask", valid, 8'h00);
        check("clr_dig",  dig,   32'h7654321A);
        blank(2);

        // Invalid pattern, then non-one-hot strobe
        e0 = n_errs;
        drive(8'h04, 7'h7F, 10, 1'b1);
        blank(4);
        check("bad_pat_err",  n_errs - e0, 1);
        check("bad_pat_mask", valid, 8'h00);
        drive(8'h03, codes[0], 10, 1'b1);
        blank(4);
        check("multi_err",  n_errs - e0, 2);
        check("multi_mask", valid, 8'h00);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 5; k++) begin
            show(k, codes[9], 10, 1'b1);
            blank(2);
        end
        blank(2);
        check("mid_mask", valid, 8'h1F);
        #3 rst = 1'b1;
        #1;
        check("arst_dig",   dig,   32'h0);
        check("arst_valid", valid, 8'h00);
        check("arst_frame", frame, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        blank(4);
        for (int k = 0; k < ND; k++) begin
            show(k, 7'h0E, 10, 1'b1);
            blank(2);
        end
        blank(6);
        check("all_f_dig", dig, 32'hFFFFFFFF);

`ifdef SEG7_CAPTURE_DP_EN
        // Decimal point on digit 3 only
        for (int k = 0; k < ND; k++) begin
            show(k, codes[k], 10, (k == 3) ? 1'b0 : 1'b1);
            blank(2);
        end
        blank(6);
        check("dp_out", dpo, 8'h08);
        check("dp_dig", dig, 32'h76543210);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
